// File: rtl/sdram_cache_pkg.sv
`default_nettype none
//============================================================================
// Module      : sdram_cache_pkg
// Description : Shared constants, clear-FSM state encoding and address helper
//               for the layer-RAM SDRAM read cache (pipe 4).
// Revision    : 1.0 - initial release
//============================================================================
package sdram_cache_pkg;

    // Default geometry: 32 layers x 32 slots x 16-bit words
    localparam int SDC_DATA_WIDTH = 16;
    localparam int SDC_ADDR_WIDTH = 10;
    localparam int LAYER_BITS     = 5;
    localparam int SLOT_BITS      = 5;

    // Clear engine state encoding
    localparam int         C_ST_W      = 2;
    localparam logic [1:0] ST_IDLE_RST = 2'd0;
    localparam logic [1:0] ST_CLEARING = 2'd1;
    localparam logic [1:0] ST_READY    = 2'd2;

    // Build a word address from a layer number and a slot within the layer
    function automatic logic [LAYER_BITS+SLOT_BITS-1:0] mk_addr(
        input logic [LAYER_BITS-1:0] layer,
        input logic [SLOT_BITS-1:0]  slot
    );
        return {layer, slot};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_cache_clr.sv
`default_nettype none
//============================================================================
// Module      : sdram_cache_clr
// Description : Post-reset clear engine. Sweeps every address once, one word
//               per clock, then parks in READY until the next reset.
// Revision    : 1.0 - initial release
//============================================================================
module sdram_cache_clr
    import sdram_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = SDC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr,
    output logic                  o_clr_busy
);

    localparam logic [ADDR_WIDTH-1:0] c_last = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] c_one  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [C_ST_W-1:0]     r_state;
    logic [C_ST_W-1:0]     w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  w_sweep;

    // State register; reset parks the engine at the start of a new sweep
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE_RST;
        else      r_state <= w_state_nxt;
    end

    // Sweep counter advances on every clearing edge and wraps after the last word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         r_cnt <= '0;
        else if (w_sweep) r_cnt <= r_cnt + c_one;
    end

    // Next state: the first edge after release starts the sweep, the last word ends it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE_RST: w_state_nxt = ST_CLEARING;
            ST_CLEARING: if (r_cnt == c_last) w_state_nxt = ST_READY;
            ST_READY:    w_state_nxt = ST_READY;
            default:     w_state_nxt = ST_IDLE_RST;
        endcase
    end

    // Outputs: word 0 is already written on the first edge out of IDLE_RST
    always_comb begin
        w_sweep    = (r_state == ST_IDLE_RST) || (r_state == ST_CLEARING);
        o_clr_we   = w_sweep;
        o_clr_busy = (r_state != ST_READY);
        o_clr_addr = r_cnt;
    end

endmodule
`default_nettype wire

// File: rtl/sdram_cache_mem.sv
`default_nettype none
//============================================================================
// Module      : sdram_cache_mem
// Description : Single-port synchronous RAM of cached SDRAM read words,
//               addressed as {layer, slot}. Registered read with write-through
//               on a same-address write; zeroed by a clear engine after reset.
//               Optional macro SDRAM_CACHE_OUTREG_EN adds a second output
//               register stage (2-cycle read latency).
// Revision    : 1.0 - initial release
//============================================================================
module sdram_cache_mem
    import sdram_cache_pkg::*;
#(
    parameter int DATA_WIDTH = SDC_DATA_WIDTH,
    parameter int ADDR_WIDTH = SDC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  clr_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_q;

    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_clr_busy;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_din;

    sdram_cache_clr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr (
        .clk        (clk),
        .rst        (rst),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_clr_busy (w_clr_busy)
    );

    // Array port mux: the clear engine owns the port while busy, user traffic is dropped
    always_comb begin
        w_we   = w_clr_busy ? w_clr_we   : wren;
        w_addr = w_clr_busy ? w_clr_addr : address;
        w_din  = w_clr_busy ? '0         : data;
    end

    // Array write; deliberately no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_addr] <= w_din;
    end

    // First read stage: zero during clear, new data on a write, stored word on a read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            r_q <= '0;
        else if (w_clr_busy) r_q <= '0;
        else if (wren)       r_q <= data;
        else                 r_q <= r_mem[address];
    end

`ifdef SDRAM_CACHE_OUTREG_EN
    logic [DATA_WIDTH-1:0] r_q2;

    // Second read stage, also forced to zero while the clear runs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            r_q2 <= '0;
        else if (w_clr_busy) r_q2 <= '0;
        else                 r_q2 <= r_q;
    end

    assign q = r_q2;
`else
    assign q = r_q;
`endif

    assign clr_busy = w_clr_busy;

endmodule
`default_nettype wire

// File: tb/tb_sdram_cache_mem.sv
`default_nettype none
//============================================================================
// Module      : tb_sdram_cache_mem
// Description : Self-checking bench for sdram_cache_mem: table vectors,
//               directed clear/reset sequences and random traffic against a
//               behavioural array model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_sdram_cache_mem;
    import sdram_cache_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
`ifdef SDRAM_CACHE_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data = '0;
    logic          wren = 1'b0;
    logic [DW-1:0] q;
    logic          clr_busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain array, words-left-to-clear count, read pipeline
    logic [DW-1:0] m_mem [0:DEPTH-1];
    int            m_left;
    logic [DW-1:0] m_s1, m_s2;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tbl [0:8];

    sdram_cache_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .data     (data),
        .wren     (wren),
        .q        (q),
        .clr_busy (clr_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_left = DEPTH;
        m_s1   = '0;
        m_s2   = '0;
    endtask

    // One clock with the given access; model updated and outputs checked after the edge
    task automatic cycle(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] n1, n2;
        wren = we; address = a; data = d;
        @(posedge clk);
        #1;
        if (m_left > 0) begin
            m_mem[DEPTH - m_left] = '0;
            m_left--;
            n1 = '0;
            n2 = '0;
        end else begin
            n1 = we ? d : m_mem[a];
            n2 = m_s1;
            if (we) m_mem[a] = d;
        end
        m_s1 = n1;
        m_s2 = n2;
        chk("q_model", {16'd0, q}, {16'd0, (LAT == 1) ? n1 : n2});
        chk("busy_model", {31'd0, clr_busy}, {31'd0, (m_left > 0)});
    endtask

    // Read address a and check the returned word once it has come through the pipeline
    task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        for (int k = 0; k < LAT; k++) cycle(1'b0, a, '0);
        chk(name, {16'd0, q}, {16'd0, exp});
    endtask

    // Run the clear to completion with a write held on address 7; returns edges spent busy
    task automatic run_clear(output int len);
        len = 0;
        while (clr_busy && len < 2000) begin
            cycle(1'b1, 10'd7, 16'hAAAA);
            len++;
        end
    endtask

    initial begin
        int            len;
        logic [DW-1:0] wd [0:31];

        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        model_reset();

        // Reset state
        #1;
        chk("rst_q", {16'd0, q}, 32'd0);
        chk("rst_busy", {31'd0, clr_busy}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Partial clear, then reset mid-clear: sweep must restart from word 0
        for (int i = 0; i < 300; i++) cycle(1'b1, 10'd7, 16'hAAAA);
        rst = 1'b0;
        #1;
        chk("midclr_q", {16'd0, q}, 32'd0);
        chk("midclr_busy", {31'd0, clr_busy}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        run_clear(len);
        chk("clr_len", len, DEPTH);

        // Table vectors, expectations taken directly from intended behaviour
        tbl[0] = '{1'b0, 10'd0,                    16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 10'd511,                  16'h0000, 16'h0000};
        tbl[2] = '{1'b0, 10'd1023,                 16'h0000, 16'h0000};
        tbl[3] = '{1'b0, 10'd7,                    16'h0000, 16'h0000};
        tbl[4] = '{1'b1, mk_addr(5'd1, 5'd5),      16'hBEEF, 16'hBEEF};
        tbl[5] = '{1'b0, 10'h025,                  16'h0000, 16'hBEEF};
        tbl[6] = '{1'b0, 10'h045,                  16'h0000, 16'h0000};
        tbl[7] = '{1'b1, 10'h3FF,                  16'h1234, 16'h1234};
        tbl[8] = '{1'b0, 10'h3FF,                  16'h0000, 16'h1234};
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].we, tbl[i].a, tbl[i].d);
            for (int k = 1; k < LAT; k++) cycle(1'b0, tbl[i].a, '0);
            chk($sformatf("tbl%0d", i), {16'd0, q}, {16'd0, tbl[i].exp});
        end

        // Fill 0..31, then asynchronous reset pulse mid-stream
        for (int i = 0; i < 32; i++) cycle(1'b1, AW'(i), 16'h1000 + 16'(i));
        read_chk("fill10", 10'd10, 16'h100A);
        #2 rst = 1'b0;
        #1;
        chk("async_q", {16'd0, q}, 32'd0);
        chk("async_busy", {31'd0, clr_busy}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        run_clear(len);
        chk("clr_len2", len, DEPTH);
        read_chk("cleared10", 10'd10, 16'h0000);

        // Streaming across layer 31: back-to-back writes then back-to-back reads
        for (int i = 0; i < 32; i++) begin
            wd[i] = 16'($urandom);
            cycle(1'b1, mk_addr(5'd31, 5'(i)), wd[i]);
        end
        for (int i = 0; i < 32 + LAT - 1; i++) begin
            cycle(1'b0, (i < 32) ? mk_addr(5'd31, 5'(i)) : 10'h3E0, '0);
            if (i >= LAT - 1) chk($sformatf("stream%0d", i - (LAT - 1)), {16'd0, q}, {16'd0, wd[i - (LAT - 1)]});
        end

        // Random traffic, biased onto a small window so reads hit earlier writes
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 47));
            cycle(1'($urandom_range(0, 2) == 0), a, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
